// File: rtl/enet_pll_lock_sequencer.sv
// rtl/enet_pll_lock_sequencer.sv - Ethernet PLL lock sequencer with guarded TX clock select
// Resets the PLL, qualifies lock, retries on timeout and switches the TX clock mux safely.
module enet_pll_lock_sequencer #(
  parameter int RST_CYCLES    = 16,
  parameter int LOCK_TIMEOUT  = 50000,
  parameter int STABLE_CYCLES = 1024,
  parameter int GUARD_CYCLES  = 8
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  input  logic [1:0] speed_req,
  output logic       pll_rst,
  output logic [1:0] clk_sel,
  output logic       clk_en,
  output logic       ready,
  output logic       speed_busy,
  output logic [7:0] retry_count,
  output logic [7:0] loss_count
);

  localparam int MAX_LS  = (LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES;
  localparam int MAX_RG  = (RST_CYCLES > GUARD_CYCLES) ? RST_CYCLES : GUARD_CYCLES;
  localparam int MAX_CNT = (MAX_LS > MAX_RG) ? MAX_LS : MAX_RG;
  localparam int CW      = $clog2(MAX_CNT + 1);

  localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
  localparam logic [CW-1:0] LOCK_LAST   = CW'(LOCK_TIMEOUT - 1);
  localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
  localparam logic [CW-1:0] GUARD_LAST  = CW'(GUARD_CYCLES - 1);

  localparam logic [2:0] S_RESET     = 3'd0;
  localparam logic [2:0] S_WAIT_LOCK = 3'd1;
  localparam logic [2:0] S_STABLE    = 3'd2;
  localparam logic [2:0] S_RUN       = 3'd3;
  localparam logic [2:0] S_GATE      = 3'd4;
  localparam logic [2:0] S_UNGATE    = 3'd5;

  logic [2:0]    state;
  logic [CW-1:0] cnt;
  logic [1:0]    target;
  logic          sync1;
  logic          lk;

  always_ff @(posedge refclk) begin
    if (rst) begin
      sync1 <= 1'b0;
      lk    <= 1'b0;
    end else begin
      sync1 <= pll_locked;
      lk    <= sync1;
    end
  end

  always_ff @(posedge refclk) begin
    if (rst) begin
      state       <= S_RESET;
      cnt         <= '0;
      target      <= 2'b10;
      pll_rst     <= 1'b1;
      clk_sel     <= 2'b10;
      clk_en      <= 1'b0;
      ready       <= 1'b0;
      speed_busy  <= 1'b0;
      retry_count <= 8'd0;
      loss_count  <= 8'd0;
    end else begin
      cnt <= cnt + CW'(1);
      case (state)
        S_RESET: begin
          if (cnt == RST_LAST) begin
            state   <= S_WAIT_LOCK;
            cnt     <= '0;
            pll_rst <= 1'b0;
          end
        end
        S_WAIT_LOCK: begin
          if (lk) begin
            state <= S_STABLE;
            cnt   <= '0;
          end else if (cnt == LOCK_LAST) begin
            state   <= S_RESET;
            cnt     <= '0;
            pll_rst <= 1'b1;
            if (retry_count != 8'hFF) retry_count <= retry_count + 8'd1;
          end
        end
        S_STABLE: begin
          if (!lk) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STABLE_LAST) begin
            state <= S_RUN;
            cnt   <= '0;
          end
        end
        S_RUN: begin
          cnt <= '0;
          if (!lk) begin
            state   <= S_RESET;
            pll_rst <= 1'b1;
            ready   <= 1'b0;
            clk_en  <= 1'b0;
            if (loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
          end else if (speed_req != 2'b11 && speed_req != clk_sel) begin
            target     <= speed_req;
            state      <= S_GATE;
            ready      <= 1'b1;
            clk_en     <= 1'b0;
            speed_busy <= 1'b1;
          end else begin
            ready      <= 1'b1;
            clk_en     <= 1'b1;
            speed_busy <= 1'b0;
          end
        end
        S_GATE, S_UNGATE: begin
          // Lock loss wins over the guard expiry so clk_sel never moves on a dead PLL.
          if (!lk) begin
            state      <= S_RESET;
            cnt        <= '0;
            pll_rst    <= 1'b1;
            ready      <= 1'b0;
            clk_en     <= 1'b0;
            speed_busy <= 1'b0;
            if (loss_count != 8'hFF) loss_count <= loss_count + 8'd1;
          end else if (cnt == GUARD_LAST) begin
            cnt <= '0;
            if (state == S_GATE) begin
              clk_sel <= target;
              state   <= S_UNGATE;
            end else begin
              state <= S_RUN;
            end
          end
        end
        default: begin
          state      <= S_RESET;
          cnt        <= '0;
          pll_rst    <= 1'b1;
          clk_en     <= 1'b0;
          ready      <= 1'b0;
          speed_busy <= 1'b0;
        end
      endcase
    end
  end

endmodule
